// File: rtl/out_uart_tx.sv
// out_uart_tx: OUT-port peripheral. Bytes strobed in with oi are queued in a
// small FIFO and serialised LSB-first onto an 8N1 UART line. stall holds the
// CPU while the FIFO is full.
// Optional build macro: OUT_UART_PARITY_EN adds an even-parity bit (8E1).
`timescale 1ns/1ps

module out_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       oi,
  output logic       stall,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx,
  output logic [7:0] frames_sent
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

`ifdef OUT_UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic          r_full, r_empty;
  logic          w_push, w_pop;
  logic [AW:0]   w_wptr_nxt, w_rptr_nxt;
  logic          w_full_nxt, w_empty_nxt;
  logic [7:0]    w_head;

  // Transmitter state
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_baud, w_baud_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift, w_shift_nxt;
  logic          r_tx, w_tx_nxt;
  logic [7:0]    r_frames, w_frames_nxt;
  logic          w_bit_end;
`ifdef OUT_UART_PARITY_EN
  logic          r_par, w_par_nxt;
`endif

  // A full FIFO rejects the write even if the FSM pops on the same edge
  assign w_push      = oi & ~r_full;
  assign w_pop       = (r_state == S_IDLE) & ~r_empty;
  assign w_wptr_nxt  = r_wptr + (AW+1)'(w_push);
  assign w_rptr_nxt  = r_rptr + (AW+1)'(w_pop);
  assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);
  assign w_full_nxt  = (w_wptr_nxt[AW] != w_rptr_nxt[AW]) &&
                       (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
  assign w_head      = r_mem[r_rptr[AW-1:0]];
  assign w_bit_end   = (r_baud == BAUD_LAST);

  assign stall       = oi & r_full;
  assign full        = r_full;
  assign empty       = r_empty;
  assign busy        = (r_state != S_IDLE);
  assign tx          = r_tx;
  assign frames_sent = r_frames;

  // FIFO data array: written on accepted strobes, contents need no reset
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= data_in;
  end

  // FIFO pointers and flags, registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_full  <= w_full_nxt;
      r_empty <= w_empty_nxt;
    end
  end

  // Transmitter next-state, baud/bit counting and serial output
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_tx_nxt     = r_tx;
    w_frames_nxt = r_frames;
`ifdef OUT_UART_PARITY_EN
    w_par_nxt    = r_par;
`endif
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        w_tx_nxt   = 1'b1;
        if (!r_empty) begin
          w_shift_nxt = w_head;
`ifdef OUT_UART_PARITY_EN
          w_par_nxt   = ^w_head;
`endif
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = S_DATA;
          w_tx_nxt    = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_nxt = '0;
          if (r_bit == 3'd7) begin
`ifdef OUT_UART_PARITY_EN
            w_state_nxt = S_PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
`endif
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_tx_nxt    = r_shift[1];
            w_bit_nxt   = r_bit + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
`ifdef OUT_UART_PARITY_EN
      S_PARITY: begin
        if (w_bit_end) begin
          w_baud_nxt  = '0;
          w_state_nxt = S_STOP;
          w_tx_nxt    = 1'b1;
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_nxt   = '0;
          w_frames_nxt = r_frames + 8'd1;
          w_state_nxt  = S_IDLE;
          w_tx_nxt     = 1'b1;
        end else begin
          w_baud_nxt = r_baud + CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_baud_nxt  = '0;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  // Transmitter control registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= 3'd0;
      r_tx     <= 1'b1;
      r_frames <= 8'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_tx     <= w_tx_nxt;
      r_frames <= w_frames_nxt;
    end
  end

  // Shifter (and parity) datapath, loaded on pop
  always_ff @(posedge clk) begin
    r_shift <= w_shift_nxt;
`ifdef OUT_UART_PARITY_EN
    r_par   <= w_par_nxt;
`endif
  end

endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx: bench for out_uart_tx. A line monitor decodes tx and checks
// each frame against a queue of accepted bytes; directed sequences cover
// latency, burst/stall, mid-frame reset and the frame counter wrap.
`timescale 1ns/1ps

module tb_out_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef OUT_UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME_CYC = NB * CPB;

  logic       clk, rst_n, oi;
  logic [7:0] data_in;
  logic       stall, full, empty, busy, tx;
  logic [7:0] frames_sent;

  out_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .oi(oi),
    .stall(stall), .full(full), .empty(empty), .busy(busy), .tx(tx),
    .frames_sent(frames_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  logic [7:0] sb_q[$];
  int         start_q[$];

  // Line monitor: samples each bit mid-cell, checks framing and data
  int          m_c = 0;
  bit          m_act = 0;
  logic [10:0] m_bits = '0;
  logic [10:0] m_last = '0;
  int          m_frames = 0;
  int          b_len = 0;
  int          b_last = 0;
  logic [3:0]  m_k;
  logic [7:0]  m_exp;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_act = 0;
      b_len = 0;
    end else begin
      if (busy === 1'b1) b_len++;
      else if (b_len != 0) begin b_last = b_len; b_len = 0; end
      if (!m_act && tx === 1'b0) begin
        m_act = 1; m_c = 0; m_bits = '0;
        start_q.push_back(cyc);
      end else if (m_act) begin
        m_c++;
      end
      if (m_act && (m_c % CPB) == CPB / 2) begin
        m_k = 4'(m_c / CPB);
        m_bits[m_k] = tx;
        if (int'(m_k) == NB - 1) begin
          m_act  = 0;
          m_last = m_bits;
          m_frames++;
          chk("start_bit", 32'(m_bits[0]), 0);
          chk("stop_bit", 32'(m_bits[NB-1]), 1);
          if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got data %0h, expected no frame", m_bits[8:1]);
          end else begin
            m_exp = sb_q.pop_front();
            chk("frame_data", 32'(m_bits[8:1]), 32'(m_exp));
`ifdef OUT_UART_PARITY_EN
            chk("parity_bit", 32'(m_bits[9]), 32'(^m_exp));
`endif
          end
        end
      end
    end
  end

  // Present a byte with oi=1 from the next falling edge until accepted
  task automatic put(input logic [7:0] b, output int stalls);
    int  n;
    bit  ok;
    n = 0; ok = 0;
    @(negedge clk);
    oi = 1'b1; data_in = b;
    for (int i = 0; i < 2 * FRAME_CYC + 10; i++) begin
      if (stall === 1'b0) begin ok = 1; break; end
      n++;
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      sb_q.push_back(b);
    end else begin
      checks++; errors++;
      $display("FAIL put_timeout: byte %0h still stalled, expected acceptance within %0d cycles", b, 2 * FRAME_CYC + 10);
    end
    stalls = n;
  endtask

  task automatic wait_idle(input int lim);
    bit done;
    done = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (empty === 1'b1 && busy === 1'b0 && !m_act) begin done = 1; break; end
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%0b empty=%0b, expected idle within %0d cycles", busy, empty, lim);
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0]  din;
    logic [10:0] frame;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  int ef;
  int st;
  int bst[6];
  int lowcnt;
  int mf;

  initial begin
`ifdef OUT_UART_PARITY_EN
    tbl[0] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}};
    tbl[1] = '{8'h00, {1'b1, 1'b0, 8'h00, 1'b0}};
    tbl[2] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}};
    tbl[3] = '{8'h07, {1'b1, 1'b1, 8'h07, 1'b0}};
    tbl[4] = '{8'h03, {1'b1, 1'b0, 8'h03, 1'b0}};
    tbl[5] = '{8'h80, {1'b1, 1'b1, 8'h80, 1'b0}};
`else
    tbl[0] = '{8'hA5, 11'b0_1_10100101_0};
    tbl[1] = '{8'h00, 11'b0_1_00000000_0};
    tbl[2] = '{8'hFF, 11'b0_1_11111111_0};
    tbl[3] = '{8'h07, 11'b0_1_00000111_0};
    tbl[4] = '{8'h03, 11'b0_1_00000011_0};
    tbl[5] = '{8'h80, 11'b0_1_10000000_0};
`endif
    rst_n = 1'b0; oi = 1'b0; data_in = 8'h00; ef = 0;
    repeat (2) @(negedge clk);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_frames", 32'(frames_sent), 0);
    chk("rst_stall", 32'(stall), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames from the vector table
    for (int i = 0; i < 6; i++) begin
      put(tbl[i].din, st);
      chk("tbl_stall", 32'(st), 0);
      @(negedge clk);
      oi = 1'b0;
      chk("tbl_queued_empty", 32'(empty), 0);
      chk("tbl_queued_tx", 32'(tx), 1);
      @(negedge clk);
      chk("tbl_start_tx", 32'(tx), 0);
      chk("tbl_start_busy", 32'(busy), 1);
      chk("tbl_popped_empty", 32'(empty), 1);
      wait_idle(FRAME_CYC + 20);
      chk("tbl_frame", 32'(m_last[NB-1:0]), 32'(tbl[i].frame[NB-1:0]));
      chk("tbl_busy_len", 32'(b_last), 32'(FRAME_CYC));
      ef++;
      chk("tbl_frames_sent", 32'(frames_sent), 32'(ef[7:0]));
    end

    // Burst of six on consecutive edges; sixth stalls until the second pops
    start_q.delete();
    for (int i = 0; i < 6; i++) put(8'(i + 1), bst[i]);
    @(negedge clk);
    oi = 1'b0;
    chk("burst_full_after_retry", 32'(full), 1);
    for (int i = 0; i < 5; i++) chk("burst_stall_early", 32'(bst[i]), 0);
    chk("burst_stall_sixth", 32'(bst[5]), 32'(FRAME_CYC - 2));
    wait_idle(7 * (FRAME_CYC + 1) + 50);
    chk("burst_frame_count", 32'(start_q.size()), 6);
    for (int i = 1; i < 6 && i < start_q.size(); i++)
      chk("burst_spacing", 32'(start_q[i] - start_q[i-1]), 32'(FRAME_CYC + 1));
    ef += 6;
    chk("burst_frames_sent", 32'(frames_sent), 32'(ef[7:0]));

    // Reset in the middle of a frame
    put(8'hA5, st);
    @(negedge clk);
    oi = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_frames", 32'(frames_sent), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    sb_q.delete();
    mf = m_frames;
    lowcnt = 0;
    for (int i = 0; i < FRAME_CYC + 10; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lowcnt++;
    end
    chk("midrst_no_frame_tx", 32'(lowcnt), 0);
    chk("midrst_no_frame_mon", 32'(m_frames), 32'(mf));
    chk("midrst_frames_after", 32'(frames_sent), 0);

    // frames_sent wrap over 256 all-zero frames
    for (int i = 0; i < 255; i++) put(8'h00, st);
    @(negedge clk);
    oi = 1'b0;
    wait_idle((DEPTH + 2) * (FRAME_CYC + 1) + 20);
    chk("wrap_255", 32'(frames_sent), 255);
    put(8'h00, st);
    @(negedge clk);
    oi = 1'b0;
    wait_idle(FRAME_CYC + 20);
    chk("wrap_0", 32'(frames_sent), 0);
    chk("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
